// File: rtl/alu_mult_seq_if.sv
// Bus between the shift-and-add multiply sequencer, its requester and the shared ALU.
// The slave side is the sequencer itself. The master side is the requester plus the ALU.
interface alu_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] seq_alu_a;
   logic [WIDTH-1:0] seq_alu_b;
   logic [3:0]       seq_alu_op;
   logic [1:0]       seq_alu_ins;
   logic [WIDTH-1:0] alu_result;

   modport slave (
      input  start, mul_a, mul_b, alu_result,
      output busy, done, prod_hi, prod_lo,
             seq_alu_a, seq_alu_b, seq_alu_op, seq_alu_ins
   );

   modport master (
      output start, mul_a, mul_b, alu_result,
      input  busy, done, prod_hi, prod_lo,
             seq_alu_a, seq_alu_b, seq_alu_op, seq_alu_ins
   );
endinterface

// File: rtl/alu_mult_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
// Every addition goes through the shared ALU; the carry out is recovered locally.
module alu_mult_seq #(
   parameter int         WIDTH  = 32,
   parameter logic [3:0] ADD_OP = 4'd1,
   parameter logic [3:0] NOP_OP = 4'd0
) (
   input logic            clk,
   input logic            rst,
   alu_mult_seq_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] sum;
   logic             carry;

   // The ALU result is only WIDTH bits: a wrapped sum is smaller than either addend.
   always_comb begin
      sum   = prod_hi;
      carry = 1'b0;
      if (prod_lo[0]) begin
         sum   = bus.alu_result;
         carry = (bus.alu_result < prod_hi);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= '0;
         prod_hi <= '0;
         prod_lo <= '0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mcand   <= bus.mul_a;
                  prod_lo <= bus.mul_b;
                  prod_hi <= '0;
                  count   <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               prod_hi <= {carry, sum[WIDTH-1:1]};
               prod_lo <= {sum[0], prod_lo[WIDTH-1:1]};
               count   <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.prod_hi     = prod_hi;
   assign bus.prod_lo     = prod_lo;
   assign bus.seq_alu_a   = prod_hi;
   assign bus.seq_alu_b   = mcand;
   assign bus.seq_alu_op  = (state == RUN) ? ADD_OP : NOP_OP;
   assign bus.seq_alu_ins = 2'b00;
endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle sequencer that computes an unsigned 32x32 -> 64-bit product by shift-and-add, reusing the existing shared ALU for every addition.
- Sits beside the ALU in the multi-cycle datapath. When busy, it owns the ALU operand and opcode inputs; when idle, it releases them (the top-level mux selects the sequencer while busy=1).
- Generates the add carry itself, because the ALU result is only 32 bits wide.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH bits.
- ADD_OP, 4'd1: ALU opcode for unsigned add.
- NOP_OP, 4'd0: ALU opcode driven when not running (ALU outputs 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- mul_a  input  WIDTH  multiplicand; latched on an accepted start.
- mul_b  input  WIDTH  multiplier; latched on an accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse when the product becomes valid.
- prod_hi  output  WIDTH  upper half of the product.
- prod_lo  output  WIDTH  lower half of the product.
- seq_alu_a  output  WIDTH  ALU operand A (current prod_hi).
- seq_alu_b  output  WIDTH  ALU operand B (latched multiplicand).
- seq_alu_op  output  4  ALU opcode.
- seq_alu_ins  output  2  ALU ins field; constant 2'b00 (overflow check disabled).
- alu_result  input  WIDTH  combinational ALU output, valid in the same cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, multiplicand reg=0, count=0, seq_alu_op=NOP_OP.
- Reset asserted mid-operation: the next edge forces IDLE and the reset values. The partial product is discarded and no done pulse is generated.
- State IDLE:
  - busy=0, seq_alu_op=NOP_OP.
  - If start=1 at an edge: mcand<=mul_a, prod_lo<=mul_b, prod_hi<=0, count<=0, go to RUN.
- State RUN (exactly WIDTH cycles):
  - busy=1. seq_alu_a=prod_hi, seq_alu_b=mcand, seq_alu_op=ADD_OP every RUN cycle (combinational from state).
  - If prod_lo[0]=1: sum=alu_result, carry=(alu_result < prod_hi), unsigned compare. Otherwise: sum=prod_hi, carry=0.
  - At the edge: {prod_hi,prod_lo} <= {carry, sum, prod_lo[WIDTH-1:1]}, count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE.
- State DONE:
  - done=1 and busy=0 for exactly one cycle; prod_hi/prod_lo hold the final product. Go to IDLE at the next edge.
  - start during DONE is ignored.
- Latency: start accepted at edge E0. RUN spans edges E1..E32. done is high during the cycle after E32 (33 cycles after acceptance).
- Next accept: start is next accepted at E34 or later (back-to-back issue period of 34 cycles).
- start while busy=1 or in DONE: ignored. mul_a and mul_b changes outside an accepted start have no effect.
- Result hold: prod_hi/prod_lo keep the last result through IDLE until the next accepted start clears them.
- Counter: count is wide enough for WIDTH-1 (5 bits at the default) and never wraps inside RUN.
- Carry correctness: with mcand=0xFFFFFFFF and prod_hi=0xFFFFFFFF, the carry must be 1 and must shift into prod_hi[WIDTH-1].
- ALU Zero/Overflow outputs are unused by this block.

Test Plan:
- Basic multiply: rst 2 cycles, then start with mul_a=3, mul_b=5 -> done pulses 33 cycles after acceptance with {prod_hi,prod_lo}=0x00000000_0000000F; busy=1 for exactly 32 cycles.
- Carry path: mul_a=0xFFFFFFFF, mul_b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
- Zero and shift: mul_a=0x80000000, mul_b=2 -> prod_hi=0x00000001, prod_lo=0. Then mul_a=0, mul_b=0x12345678 -> product 0 and seq_alu_op=ADD_OP throughout RUN.
- Start while busy: start 7*9, pulse start with mul_a=100 at RUN cycle 10 and again during DONE -> result 63, exactly one done pulse, no second run started.
- Reset mid-operation: assert rst at RUN cycle 15 -> next edge busy=0, done=0, prod_hi=prod_lo=0, seq_alu_op=0. A new start 6*7 afterwards yields 42.
- Back-to-back: start held high continuously -> accepts at E0 and E34 only; done pulses 34 cycles apart; the result holds between runs.
